// File: rtl/data_tx_pkg.sv
// rtl/data_tx_pkg.sv - shared types, constants and helpers for the data TX serializer
//
// Contents:
//   tx_state_e          FSM state encoding (IDLE=0, HEADER=1, TRANSMIT=2)
//   DEFAULT_HEADER_BYTE default sync/header byte value
//   clog2_min1()        ceil(log2(value)), never less than 1, for index widths
package data_tx_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HEADER   = 2'd1,
        TRANSMIT = 2'd2
    } tx_state_e;

    localparam logic [7:0] DEFAULT_HEADER_BYTE = 8'hA5;

    // A one-byte word still needs a 1-bit index register, hence the floor of 1.
    function automatic int clog2_min1(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/data_tx_serializer_if.sv
// rtl/data_tx_serializer_if.sv - FIFO-side and UART-side handshake bundle of the serializer
//
// Signals:
//   FIFOData / FIFODataValid / ReadyToRead   word input from the acquisition FIFO
//   Flush                                    synchronous abort of the current word
//   DataOut / UARTRequestToSend / UARTDataLoaded  byte handshake towards the UART
//   Busy / WordCount                         status readback
// Modports:
//   master  drives FIFO data, Flush and UARTDataLoaded (environment side)
//   slave   the serializer itself
interface data_tx_serializer_if #(
    parameter int WORD_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
);
    logic [WORD_WIDTH-1:0] FIFOData;
    logic                  FIFODataValid;
    logic                  ReadyToRead;
    logic                  Flush;
    logic [BYTE_WIDTH-1:0] DataOut;
    logic                  UARTRequestToSend;
    logic                  UARTDataLoaded;
    logic                  Busy;
    logic [CNT_WIDTH-1:0]  WordCount;

    modport master (
        output FIFOData, FIFODataValid, Flush, UARTDataLoaded,
        input  ReadyToRead, DataOut, UARTRequestToSend, Busy, WordCount
    );

    modport slave (
        input  FIFOData, FIFODataValid, Flush, UARTDataLoaded,
        output ReadyToRead, DataOut, UARTRequestToSend, Busy, WordCount
    );

endinterface

// File: rtl/tx_byte_shifter.sv
// rtl/tx_byte_shifter.sv - word shift register presenting one byte at a time
//
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_load, i_data  capture a new word
//   i_shift         advance to the next byte (zero-fill)
//   i_clear         discard the word (highest priority)
//   o_byte          byte currently at the output end of the register
module tx_byte_shifter #(
    parameter int WORD_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int MSB_FIRST  = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic [WORD_WIDTH-1:0] i_data,
    input  logic                  i_shift,
    input  logic                  i_clear,
    output logic [BYTE_WIDTH-1:0] o_byte
);
    logic [WORD_WIDTH-1:0] r_shift;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
        end else if (i_load) begin
            r_shift <= i_data;
        end else if (i_shift) begin
            // Shifting by the full width when WORD_WIDTH==BYTE_WIDTH yields zero.
            if (MSB_FIRST != 0) begin
                r_shift <= r_shift << BYTE_WIDTH;
            end else begin
                r_shift <= r_shift >> BYTE_WIDTH;
            end
        end
    end

    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign o_byte = r_shift[WORD_WIDTH-1 -: BYTE_WIDTH];
        end else begin : g_lsb
            assign o_byte = r_shift[BYTE_WIDTH-1:0];
        end
    endgenerate

endmodule

// File: rtl/data_tx_serializer.sv
// rtl/data_tx_serializer.sv - FIFO word to UART byte serializer with optional header
//
// Ports:
//   Clk, Reset_n  clock, asynchronous active-low reset
//   bus           data_tx_serializer_if.slave: FIFO word input, UART byte
//                 handshake, Flush, Busy and WordCount status
// All outputs decode registered state only; UARTDataLoaded never reaches an
// output combinationally.
module data_tx_serializer
    import data_tx_pkg::*;
#(
    parameter int                    WORD_WIDTH  = 32,
    parameter int                    BYTE_WIDTH  = 8,
    parameter int                    MSB_FIRST   = 1,
    parameter int                    HEADER_EN   = 0,
    parameter logic [BYTE_WIDTH-1:0] HEADER_BYTE = BYTE_WIDTH'(DEFAULT_HEADER_BYTE),
    parameter int                    CNT_WIDTH   = 16
) (
    input  logic                Clk,
    input  logic                Reset_n,
    data_tx_serializer_if.slave bus
);
    localparam int BYTES = WORD_WIDTH / BYTE_WIDTH;
    localparam int IDX_W = clog2_min1(BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    tx_state_e             r_state;
    tx_state_e             w_state_next;
    logic [IDX_W-1:0]      r_byte_idx;
    logic [CNT_WIDTH-1:0]  r_word_count;
    logic                  w_load;
    logic                  w_shift;
    logic                  w_clear;
    logic                  w_idx_clr;
    logic                  w_idx_inc;
    logic                  w_cnt_inc;
    logic [BYTE_WIDTH-1:0] w_byte;

    tx_byte_shifter #(
        .WORD_WIDTH (WORD_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH),
        .MSB_FIRST  (MSB_FIRST)
    ) u_shifter (
        .i_clk   (Clk),
        .i_rst_n (Reset_n),
        .i_load  (w_load),
        .i_data  (bus.FIFOData),
        .i_shift (w_shift),
        .i_clear (w_clear),
        .o_byte  (w_byte)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= IDLE;
            r_byte_idx   <= '0;
            r_word_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_idx_clr) begin
                r_byte_idx <= '0;
            end else if (w_idx_inc) begin
                r_byte_idx <= r_byte_idx + 1'b1;
            end
            if (w_cnt_inc) begin
                r_word_count <= r_word_count + 1'b1;
            end
        end
    end

    // Flush is checked first so it wins over both a load and a word accept.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_clear      = 1'b0;
        w_idx_clr    = 1'b0;
        w_idx_inc    = 1'b0;
        w_cnt_inc    = 1'b0;
        if (bus.Flush) begin
            w_state_next = IDLE;
            w_clear      = 1'b1;
            w_idx_clr    = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.FIFODataValid) begin
                        w_load       = 1'b1;
                        w_idx_clr    = 1'b1;
                        w_state_next = (HEADER_EN != 0) ? HEADER : TRANSMIT;
                    end
                end
                HEADER: begin
                    if (bus.UARTDataLoaded) begin
                        w_state_next = TRANSMIT;
                    end
                end
                TRANSMIT: begin
                    if (bus.UARTDataLoaded) begin
                        w_shift = 1'b1;
                        if (r_byte_idx == LAST_IDX) begin
                            // Clearing rather than incrementing keeps the
                            // index in range when BYTES is not a power of two.
                            w_idx_clr    = 1'b1;
                            w_cnt_inc    = 1'b1;
                            w_state_next = IDLE;
                        end else begin
                            w_idx_inc = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_clear      = 1'b1;
                    w_idx_clr    = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        bus.DataOut = '0;
        case (r_state)
            HEADER:   bus.DataOut = HEADER_BYTE;
            TRANSMIT: bus.DataOut = w_byte;
            default:  bus.DataOut = '0;
        endcase
    end

    assign bus.UARTRequestToSend = (r_state == HEADER) || (r_state == TRANSMIT);
    assign bus.Busy              = (r_state != IDLE);
    assign bus.ReadyToRead       = (r_state == IDLE);
    assign bus.WordCount         = r_word_count;

endmodule

// File: tb/tb_data_tx_serializer.sv
// tb/tb_data_tx_serializer.sv - self-checking bench for data_tx_serializer
module tb_data_tx_serializer;

    logic clk;
    logic rst_n;

    // Instance 0: defaults. 1: LSB first, header, 4-bit counter. 2: 16-bit words.
    data_tx_serializer_if #(.WORD_WIDTH(32), .BYTE_WIDTH(8), .CNT_WIDTH(16)) ifa ();
    data_tx_serializer_if #(.WORD_WIDTH(32), .BYTE_WIDTH(8), .CNT_WIDTH(4))  ifb ();
    data_tx_serializer_if #(.WORD_WIDTH(16), .BYTE_WIDTH(8), .CNT_WIDTH(16)) ifc ();

    data_tx_serializer u_a (.Clk(clk), .Reset_n(rst_n), .bus(ifa));

    data_tx_serializer #(
        .MSB_FIRST(0), .HEADER_EN(1), .CNT_WIDTH(4)
    ) u_b (.Clk(clk), .Reset_n(rst_n), .bus(ifb));

    data_tx_serializer #(
        .WORD_WIDTH(16), .BYTE_WIDTH(8)
    ) u_c (.Clk(clk), .Reset_n(rst_n), .bus(ifc));

    int          sel;
    logic [31:0] fdata;
    logic        fvalid;
    logic        flush;
    logic        loaded;

    logic [7:0]  dout;
    logic        rts;
    logic        busy;
    logic        rtr;
    logic [15:0] wcnt;

    int n_cmp;
    int n_err;

    assign ifa.FIFOData       = fdata;
    assign ifa.FIFODataValid  = fvalid && (sel == 0);
    assign ifa.Flush          = flush && (sel == 0);
    assign ifa.UARTDataLoaded = loaded && (sel == 0);
    assign ifb.FIFOData       = fdata;
    assign ifb.FIFODataValid  = fvalid && (sel == 1);
    assign ifb.Flush          = flush && (sel == 1);
    assign ifb.UARTDataLoaded = loaded && (sel == 1);
    assign ifc.FIFOData       = fdata[15:0];
    assign ifc.FIFODataValid  = fvalid && (sel == 2);
    assign ifc.Flush          = flush && (sel == 2);
    assign ifc.UARTDataLoaded = loaded && (sel == 2);

    always_comb begin
        dout = ifa.DataOut;
        rts  = ifa.UARTRequestToSend;
        busy = ifa.Busy;
        rtr  = ifa.ReadyToRead;
        wcnt = ifa.WordCount;
        if (sel == 1) begin
            dout = ifb.DataOut;
            rts  = ifb.UARTRequestToSend;
            busy = ifb.Busy;
            rtr  = ifb.ReadyToRead;
            wcnt = {12'b0, ifb.WordCount};
        end else if (sel == 2) begin
            dout = ifc.DataOut;
            rts  = ifc.UARTRequestToSend;
            busy = ifc.Busy;
            rtr  = ifc.ReadyToRead;
            wcnt = ifc.WordCount;
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 1000000", $time);
        $fatal(1);
    end

    typedef struct {
        int          sel;
        logic [31:0] word;
        int          nb;     // handshakes including header
        logic [39:0] exp;    // expected bytes, first byte in the top octet
        int          stall;  // cycles the UART waits before each load
        bit          hold;   // keep FIFODataValid high for the whole word
        logic [15:0] wcnt;   // WordCount after the word completes
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0] eb;
        sel = v.sel;
        #0;
        chk("idle_rtr", {31'b0, rtr}, 32'd1);
        fdata  = v.word;
        fvalid = 1'b1;
        @(negedge clk);
        if (!v.hold) fvalid = 1'b0;
        for (int k = 0; k < v.nb; k++) begin
            eb = v.exp[39-8*k -: 8];
            chk("byte", {24'b0, dout}, {24'b0, eb});
            chk("rts", {31'b0, rts}, 32'd1);
            chk("busy", {31'b0, busy}, 32'd1);
            chk("rtr_busy", {31'b0, rtr}, 32'd0);
            for (int s = 0; s < v.stall; s++) begin
                @(negedge clk);
                chk("hold_byte", {24'b0, dout}, {24'b0, eb});
                chk("hold_rts", {31'b0, rts}, 32'd1);
            end
            loaded = 1'b1;
            if (k == v.nb - 1) fvalid = 1'b0;
            @(negedge clk);
            loaded = 1'b0;
        end
        chk("done_rts", {31'b0, rts}, 32'd0);
        chk("done_busy", {31'b0, busy}, 32'd0);
        chk("done_rtr", {31'b0, rtr}, 32'd1);
        chk("done_dout", {24'b0, dout}, 32'd0);
        chk("wcnt", {16'b0, wcnt}, {16'b0, v.wcnt});
    endtask

    initial begin
        vec_t w;
        n_cmp  = 0;
        n_err  = 0;
        sel    = 0;
        fdata  = '0;
        fvalid = 1'b0;
        flush  = 1'b0;
        loaded = 1'b0;
        rst_n  = 1'b0;

        vecs[0] = '{0, 32'h11223344, 4, 40'h11223344_00, 0,  1'b0, 16'd1};
        vecs[1] = '{1, 32'hA1B2C3D4, 5, 40'hA5D4C3B2A1,  0,  1'b0, 16'd1};
        vecs[2] = '{2, 32'h0000CAFE, 2, 40'hCAFE000000,  0,  1'b0, 16'd1};
        vecs[3] = '{0, 32'h55AA0FF0, 4, 40'h55AA0FF0_00, 20, 1'b1, 16'd2};
        vecs[4] = '{1, 32'h00000001, 5, 40'hA501000000,  1,  1'b0, 16'd2};
        vecs[5] = '{0, 32'hFFFFFFFF, 4, 40'hFFFFFFFF_00, 3,  1'b0, 16'd3};

        #12;
        chk("rst_rts", {31'b0, rts}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_dout", {24'b0, dout}, 32'd0);
        chk("rst_rtr", {31'b0, rtr}, 32'd1);
        chk("rst_wcnt", {16'b0, wcnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Flush together with the load of byte index 2 of DEADBEEF.
        sel    = 0;
        fdata  = 32'hDEADBEEF;
        fvalid = 1'b1;
        @(negedge clk);
        fvalid = 1'b0;
        chk("fl_b0", {24'b0, dout}, 32'hDE);
        loaded = 1'b1;
        @(negedge clk);
        chk("fl_b1", {24'b0, dout}, 32'hAD);
        @(negedge clk);
        chk("fl_b2", {24'b0, dout}, 32'hBE);
        flush = 1'b1;
        @(negedge clk);
        loaded = 1'b0;
        flush  = 1'b0;
        chk("fl_rts", {31'b0, rts}, 32'd0);
        chk("fl_busy", {31'b0, busy}, 32'd0);
        chk("fl_rtr", {31'b0, rtr}, 32'd1);
        chk("fl_wcnt", {16'b0, wcnt}, 32'd3);
        w = '{0, 32'h01020304, 4, 40'h01020304_00, 0, 1'b0, 16'd4};
        run_vec(w);

        // Flush beats a word accept in IDLE.
        fdata  = 32'h12345678;
        fvalid = 1'b1;
        flush  = 1'b1;
        @(negedge clk);
        fvalid = 1'b0;
        flush  = 1'b0;
        chk("flacc_busy", {31'b0, busy}, 32'd0);
        chk("flacc_rtr", {31'b0, rtr}, 32'd1);

        // UARTDataLoaded while IDLE changes nothing.
        loaded = 1'b1;
        @(negedge clk);
        loaded = 1'b0;
        chk("idle_ld_rts", {31'b0, rts}, 32'd0);
        chk("idle_ld_busy", {31'b0, busy}, 32'd0);
        chk("idle_ld_wcnt", {16'b0, wcnt}, 32'd4);

        // 15 more words on the 4-bit counter: 17 in total wraps to 1.
        for (int i = 0; i < 15; i++) begin
            w.sel   = 1;
            w.word  = 32'h10203040 + 32'(i * 32'h01010101);
            w.nb    = 5;
            w.exp   = {8'hA5, w.word[7:0], w.word[15:8], w.word[23:16], w.word[31:24]};
            w.stall = 0;
            w.hold  = 1'b0;
            w.wcnt  = 16'((3 + i) % 16);
            run_vec(w);
        end
        chk("wrap_wcnt", {16'b0, wcnt}, 32'd1);

        // Asynchronous reset mid-word, between clock edges.
        sel    = 0;
        fdata  = 32'h99887766;
        fvalid = 1'b1;
        @(negedge clk);
        fvalid = 1'b0;
        chk("ar_b0", {24'b0, dout}, 32'h99);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_rts", {31'b0, rts}, 32'd0);
        chk("ar_busy", {31'b0, busy}, 32'd0);
        chk("ar_wcnt", {16'b0, wcnt}, 32'd0);
        chk("ar_dout", {24'b0, dout}, 32'd0);
        chk("ar_rtr", {31'b0, rtr}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        w = '{0, 32'h0A0B0C0D, 4, 40'h0A0B0C0D_00, 0, 1'b0, 16'd1};
        run_vec(w);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_tx_serializer.md
Name: data_tx_serializer

Overview:
Parametrised word-to-byte serializer between the acquisition-data FIFO and the UART transmitter. It pops one WORD_WIDTH word from the FIFO and presents it to the UART as BYTES = WORD_WIDTH/BYTE_WIDTH bytes, one byte per UARTDataLoaded handshake. Byte order is selectable, and an optional sync/header byte can precede each word. It adds a flush control, a busy flag and a sent-word counter for status readback.

Parameters:
WORD_WIDTH, 32, FIFO word width; must be an integer multiple of BYTE_WIDTH.
BYTE_WIDTH, 8, UART character width.
MSB_FIRST, 1, 1 = most-significant byte sent first; 0 = least-significant byte first.
HEADER_EN, 0, 1 = send HEADER_BYTE before each word.
HEADER_BYTE, 8'hA5, header value; BYTE_WIDTH bits wide.
CNT_WIDTH, 16, width of WordCount.

Ports:
Clk  in  1  system clock; all state updates on the rising edge.
Reset_n  in  1  asynchronous, active-low reset.
FIFOData  in  WORD_WIDTH  FIFO read data.
FIFODataValid  in  1  FIFOData valid.
ReadyToRead  out  1  serializer can accept a word (FIFO read enable).
Flush  in  1  synchronous abort of the current word.
DataOut  out  BYTE_WIDTH  byte presented to the UART.
UARTRequestToSend  out  1  DataOut holds a valid byte.
UARTDataLoaded  in  1  UART has taken DataOut this cycle.
Busy  out  1  a word is in progress (header or data phase).
WordCount  out  CNT_WIDTH  count of fully transmitted words; wraps.

Behaviour:
- Derived values:
  - BYTES = WORD_WIDTH/BYTE_WIDTH.
  - Byte index width = max(1, clog2(BYTES)).
- Reset (Reset_n low, asynchronous): state IDLE, shift register 0, byte index 0, WordCount 0.
  - Outputs during/after reset: UARTRequestToSend=0, Busy=0, DataOut=0, ReadyToRead=1.
- States: IDLE, HEADER, TRANSMIT. All outputs are decoded from registered state; no combinational path from UARTDataLoaded to any output.
- IDLE:
  - ReadyToRead=1.
  - Word accepted on FIFODataValid & ReadyToRead: latch FIFOData into the shift register and clear the byte index.
  - Next state is HEADER if HEADER_EN, else TRANSMIT.
  - UARTRequestToSend=0. DataOut=0.
- HEADER:
  - UARTRequestToSend=1, DataOut=HEADER_BYTE.
  - On UARTDataLoaded -> TRANSMIT.
- TRANSMIT:
  - UARTRequestToSend=1.
  - DataOut = the top BYTE_WIDTH bits of the shift register if MSB_FIRST, else the bottom BYTE_WIDTH bits.
  - On UARTDataLoaded: shift by BYTE_WIDTH (left if MSB_FIRST, else right), zero-fill, increment the byte index.
  - If the byte index was BYTES-1 when UARTDataLoaded arrived: go to IDLE and increment WordCount (mod 2^CNT_WIDTH).
- DataOut is stable while UARTRequestToSend=1 and UARTDataLoaded=0. The UART may hold off indefinitely.
- Busy = (state != IDLE). ReadyToRead = (state == IDLE).
- Latency:
  - Accept edge -> first byte (or header) valid on the next cycle.
  - Minimum one IDLE cycle between consecutive words.
  - Word period is at least BYTES+HEADER_EN+1 cycles.
- UARTDataLoaded while IDLE is ignored. FIFODataValid outside IDLE is ignored (no pop).
- Flush:
  - In any state: next state IDLE, byte index 0, shift register 0, WordCount unchanged.
  - Flush takes priority over UARTDataLoaded and over word accept in the same cycle.
- BYTES=1: TRANSMIT lasts a single handshake.
- Reset_n asserted mid-word: the word is dropped; WordCount is cleared.

Decomposition:
- Package data_tx_pkg holds:
  - the state encoding constants (IDLE=2'd0, HEADER=2'd1, TRANSMIT=2'd2);
  - the clog2 helper function;
  - the default HEADER_BYTE constant.
- One sub-module, tx_byte_shifter, parametrised by WORD_WIDTH, BYTE_WIDTH and MSB_FIRST.
  - Inputs: load, shift, clear.
  - Output: current byte.
  - The FSM, counters and handshakes stay in data_tx_serializer.

Test Plan:
1. Defaults; FIFOData=32'h11223344, FIFODataValid pulse, UARTDataLoaded one cycle after each request -> DataOut 8'h11, 8'h22, 8'h33, 8'h44; UARTRequestToSend drops after the fourth load; WordCount=1; ReadyToRead high again.
2. MSB_FIRST=0, HEADER_EN=1, word 32'hA1B2C3D4 -> bytes 8'hA5, 8'hD4, 8'hC3, 8'hB2, 8'hA1; Busy high for exactly those 5 handshakes.
3. UART stalls 20 cycles between loads -> DataOut and UARTRequestToSend held constant; FIFODataValid held high throughout does not cause a second pop until IDLE.
4. Flush asserted together with UARTDataLoaded on byte 2 of 32'hDEADBEEF -> IDLE next cycle, WordCount unchanged; next word 32'h01020304 is sent complete from 8'h01.
5. Reset_n pulled low asynchronously mid-word, with no clock edge -> UARTRequestToSend=0, Busy=0, WordCount=0 immediately; normal operation after release.
6. CNT_WIDTH=4; 17 words sent -> WordCount wraps to 1. Also WORD_WIDTH=16, BYTE_WIDTH=8 with 16'hCAFE -> 8'hCA, 8'hFE.
